// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one pipelined memory port between the cpu and ard requesters.
// Read data returns to its issuer RD_LAT+1 edges after issue, in issue order.
module mem_port_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ard_req,
    input  logic              ard_we,
    input  logic [ADDR_W-1:0] ard_addr,
    input  logic [DATA_W-1:0] ard_wdata,
    output logic              ard_gnt,
    output logic              ard_rvalid,
    output logic [DATA_W-1:0] ard_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              cpu_gnt_q, cpu_gnt_d, ard_gnt_q, ard_gnt_d;
    logic              cpu_rvalid_q, cpu_rvalid_d, ard_rvalid_q, ard_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, ard_rdata_q, ard_rdata_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              owner_q, owner_d;       // 1 = current mem access belongs to ard
    logic              last_ard_q, last_ard_d; // 1 = ard holds the most recent grant
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d, tag_own_q, tag_own_d;
    logic              cpu_elig, ard_elig, pick_cpu, pick_ard, issue;

    always_comb begin
        // A request already granted this cycle is still high; it must not issue twice.
        cpu_elig = cpu_req & ~cpu_gnt_q;
        ard_elig = ard_req & ~ard_gnt_q;
        pick_ard = ard_elig & (~cpu_elig | ~last_ard_q);
        pick_cpu = cpu_elig & ~pick_ard;
        issue    = pick_cpu | pick_ard;

        cpu_gnt_d   = pick_cpu;
        ard_gnt_d   = pick_ard;
        mem_en_d    = issue;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        owner_d     = owner_q;
        last_ard_d  = last_ard_q;
        if (issue) begin
            mem_we_d    = pick_ard ? ard_we    : cpu_we;
            mem_addr_d  = pick_ard ? ard_addr  : cpu_addr;
            mem_wdata_d = pick_ard ? ard_wdata : cpu_wdata;
            owner_d     = pick_ard;
            last_ard_d  = pick_ard;
        end

        // The tag enters one edge after issue, taken from the registered mem_* strobe,
        // so it leaves exactly when mem_rdata has been valid for one cycle.
        tag_vld_d    = tag_vld_q << 1;
        tag_own_d    = tag_own_q << 1;
        tag_vld_d[0] = mem_en_q & ~mem_we_q;
        tag_own_d[0] = owner_q;

        cpu_rvalid_d = 1'b0;
        ard_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        ard_rdata_d  = ard_rdata_q;
        if (tag_vld_q[RD_LAT-1]) begin
            if (tag_own_q[RD_LAT-1]) begin
                ard_rvalid_d = 1'b1;
                ard_rdata_d  = mem_rdata;
            end else begin
                cpu_rvalid_d = 1'b1;
                cpu_rdata_d  = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_gnt_q    <= 1'b0;
            ard_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            ard_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            ard_rdata_q  <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            owner_q      <= 1'b0;
            last_ard_q   <= 1'b1;
            tag_vld_q    <= '0;
            tag_own_q    <= '0;
        end else begin
            cpu_gnt_q    <= cpu_gnt_d;
            ard_gnt_q    <= ard_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            ard_rvalid_q <= ard_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ard_rdata_q  <= ard_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            owner_q      <= owner_d;
            last_ard_q   <= last_ard_d;
            tag_vld_q    <= tag_vld_d;
            tag_own_q    <= tag_own_d;
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign ard_gnt    = ard_gnt_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign ard_rvalid = ard_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign ard_rdata  = ard_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
